rs_mem: RTL and testbench

- Reservation station for load/store µops, directly upstream of fu_mem.
- Accepts dispatched memory µops and tracks source-operand readiness via CDB wakeup.
- Issues the oldest ready entry (by ROB age) to fu_mem when fu_mem can accept it.
- Flushes wrong-path entries on branch mispredict.

---
 rtl/types_pkg.sv | 29 ++
 rtl/rs_mem_select.sv | 28 ++
 rtl/rs_mem.sv | 179 +++++++++++++++++
 tb/tb_rs_mem.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared rs_mem types, opcodes and ROB age helper
package types_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  ps1;
    logic [6:0]  ps2;
    logic [6:0]  pd;
    logic [31:0] imm;
    logic [4:0]  rob_tag;
  } rs_data;

  typedef struct packed {
    rs_data data;
    logic   valid;
    logic   p1_rdy;
    logic   p2_rdy;
  } rs_mem_entry;

  // Distance from the ROB head; smaller means older, wrap-around is intentional.
  function automatic logic [4:0] rob_age(input logic [4:0] tag, input logic [4:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/rs_mem_select.sv
// rtl/rs_mem_select.sv - combinational oldest-ready picker over the RS entries
module rs_mem_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         ready_i,
  input  logic [DEPTH-1:0][4:0]    age_i,
  output logic                     found_o,
  output logic [$clog2(DEPTH)-1:0] index_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [4:0] best_age;

  always_comb begin
    found_o  = 1'b0;
    index_o  = '0;
    best_age = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_i[i] && (!found_o || (age_i[i] < best_age))) begin
        found_o  = 1'b1;
        index_o  = IDX_W'(i);
        best_age = age_i[i];
      end
    end
  end

endmodule

// File: rtl/rs_mem.sv
// rtl/rs_mem.sv - load/store reservation station feeding fu_mem
// Optional RS_MEM_PERF_EN adds the stall_cycles output.
module rs_mem
  import types_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dispatch_valid,
  input  logic [6:0]             dispatch_opcode,
  input  logic [2:0]             dispatch_funct3,
  input  logic [6:0]             dispatch_ps1,
  input  logic [6:0]             dispatch_ps2,
  input  logic                   dispatch_ps1_ready,
  input  logic                   dispatch_ps2_ready,
  input  logic [6:0]             dispatch_pd,
  input  logic [31:0]            dispatch_imm,
  input  logic [4:0]             dispatch_rob_tag,
  input  logic [NUM_CDB-1:0]     cdb_valid,
  input  logic [7*NUM_CDB-1:0]   cdb_pd,
  input  logic [4:0]             rob_head,
  input  logic                   mispredict,
  input  logic [4:0]             mispredict_tag,
  input  logic                   fu_mem_ready,
  output logic                   issued,
  output rs_data                 issue_data,
  output logic                   rs_full,
`ifdef RS_MEM_PERF_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic [$clog2(DEPTH):0] rs_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_mem_entry        entries_q [DEPTH];
  rs_mem_entry        entries_d [DEPTH];
  logic               issued_q, issued_d;
  rs_data             issue_data_q, issue_data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;

  logic [DEPTH-1:0]      sel_ready;
  logic [DEPTH-1:0][4:0] sel_age;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  rs_mem_entry           disp_entry;

  // Physical reg 0 never matches a broadcast; it is handled as always ready.
  function automatic logic cdb_hit(input logic [6:0] preg,
                                   input logic [NUM_CDB-1:0] vld,
                                   input logic [7*NUM_CDB-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (vld[k] && (tags[7*k +: 7] == preg) && (preg != 7'd0)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel_ready[i] = entries_q[i].valid && entries_q[i].p1_rdy && entries_q[i].p2_rdy;
      sel_age[i]   = rob_age(entries_q[i].data.rob_tag, rob_head);
    end
  end

  rs_mem_select #(.DEPTH(DEPTH)) u_select (
    .ready_i (sel_ready),
    .age_i   (sel_age),
    .found_o (sel_found),
    .index_o (sel_idx)
  );

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    disp_entry.data.opcode  = dispatch_opcode;
    disp_entry.data.funct3  = dispatch_funct3;
    disp_entry.data.ps1     = dispatch_ps1;
    disp_entry.data.ps2     = dispatch_ps2;
    disp_entry.data.pd      = dispatch_pd;
    disp_entry.data.imm     = dispatch_imm;
    disp_entry.data.rob_tag = dispatch_rob_tag;
    disp_entry.valid        = 1'b1;
    disp_entry.p1_rdy       = dispatch_ps1_ready || (dispatch_ps1 == 7'd0) ||
                              cdb_hit(dispatch_ps1, cdb_valid, cdb_pd);
    disp_entry.p2_rdy       = (dispatch_opcode == OPC_LOAD) || dispatch_ps2_ready ||
                              (dispatch_ps2 == 7'd0) ||
                              cdb_hit(dispatch_ps2, cdb_valid, cdb_pd);
  end

  always_comb begin
    entries_d    = entries_q;
    issued_d     = 1'b0;
    issue_data_d = issue_data_q;
    count_d      = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid) begin
        if (cdb_hit(entries_q[i].data.ps1, cdb_valid, cdb_pd)) entries_d[i].p1_rdy = 1'b1;
        if (cdb_hit(entries_q[i].data.ps2, cdb_valid, cdb_pd)) entries_d[i].p2_rdy = 1'b1;
      end
    end

    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_q[i].valid &&
            (rob_age(entries_q[i].data.rob_tag, rob_head) > rob_age(mispredict_tag, rob_head)))
          entries_d[i].valid = 1'b0;
      end
    end else begin
      if (sel_found && fu_mem_ready) begin
        issued_d                 = 1'b1;
        issue_data_d             = entries_q[sel_idx].data;
        entries_d[sel_idx].valid = 1'b0;
      end
      // The free slot is always distinct from the issuing one, so both may happen together.
      if (dispatch_valid && !full_q && free_found) entries_d[free_idx] = disp_entry;
    end

    for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(entries_d[i].valid);
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      issued_q     <= 1'b0;
      issue_data_q <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      issued_q     <= issued_d;
      issue_data_q <= issue_data_d;
      count_q      <= count_d;
      full_q       <= full_d;
    end
  end

  assign issued     = issued_q;
  assign issue_data = issue_data_q;
  assign rs_count   = count_q;
  assign rs_full    = full_q;

`ifdef RS_MEM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (sel_found && !fu_mem_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  dispatch_while_full: assert property (@(posedge clk) disable iff (reset)
                                        !(dispatch_valid && full_q))
    else $warning("rs_mem: dispatch dropped while full");

endmodule

// File: tb/tb_rs_mem.sv
// tb/tb_rs_mem.sv - self-checking bench for rs_mem against a queue-based reference model
module tb_rs_mem;
  import types_pkg::*;

  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 dispatch_valid;
  logic [6:0]           dispatch_opcode;
  logic [2:0]           dispatch_funct3;
  logic [6:0]           dispatch_ps1, dispatch_ps2, dispatch_pd;
  logic                 dispatch_ps1_ready, dispatch_ps2_ready;
  logic [31:0]          dispatch_imm;
  logic [4:0]           dispatch_rob_tag;
  logic [NUM_CDB-1:0]   cdb_valid;
  logic [7*NUM_CDB-1:0] cdb_pd;
  logic [4:0]           rob_head, mispredict_tag;
  logic                 mispredict, fu_mem_ready;
  logic                 issued, rs_full;
  rs_data               issue_data;
  logic [3:0]           rs_count;
`ifdef RS_MEM_PERF_EN
  logic [31:0]          stall_cycles;
`endif

  always #5 clk = ~clk;

  rs_mem #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_funct3(dispatch_funct3), .dispatch_ps1(dispatch_ps1),
    .dispatch_ps2(dispatch_ps2), .dispatch_ps1_ready(dispatch_ps1_ready),
    .dispatch_ps2_ready(dispatch_ps2_ready), .dispatch_pd(dispatch_pd),
    .dispatch_imm(dispatch_imm), .dispatch_rob_tag(dispatch_rob_tag),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .rob_head(rob_head),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .fu_mem_ready(fu_mem_ready), .issued(issued), .issue_data(issue_data),
    .rs_full(rs_full),
`ifdef RS_MEM_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .rs_count(rs_count)
  );

  typedef struct {
    rs_data d;
    bit     r1;
    bit     r2;
  } mitem_t;

  mitem_t      mq[$];
  int          dut_tags[$];
  bit          exp_issued;
  rs_data      exp_data;
  logic [31:0] exp_stall;
  int          passes = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int age(input logic [4:0] t);
    return (int'(t) - int'(rob_head) + 32) % 32;
  endfunction

  function automatic bit hit(input logic [6:0] p);
    if (p == 7'd0) return 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && (cdb_pd[7*k +: 7] == p)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit tag_live(input logic [4:0] t);
    foreach (mq[i]) if (mq[i].d.rob_tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: the oldest ready µop leaves, survivors snoop the CDB, then the new µop joins.
  task automatic model_step();
    int     best = -1;
    int     n0   = mq.size();
    mitem_t it;
    foreach (mq[i])
      if (mq[i].r1 && mq[i].r2 && (best < 0 || age(mq[i].d.rob_tag) < age(mq[best].d.rob_tag)))
        best = i;
    if (best >= 0 && !fu_mem_ready && exp_stall != 32'hffff_ffff) exp_stall++;
    exp_issued = 1'b0;
    if (mispredict) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (age(mq[i].d.rob_tag) > age(mispredict_tag)) mq.delete(i);
    end else if (best >= 0 && fu_mem_ready) begin
      exp_issued = 1'b1;
      exp_data   = mq[best].d;
      mq.delete(best);
    end
    foreach (mq[i]) begin
      if (hit(mq[i].d.ps1)) mq[i].r1 = 1'b1;
      if (hit(mq[i].d.ps2)) mq[i].r2 = 1'b1;
    end
    if (!mispredict && dispatch_valid && n0 < DEPTH) begin
      it.d  = '{opcode: dispatch_opcode, funct3: dispatch_funct3, ps1: dispatch_ps1,
                ps2: dispatch_ps2, pd: dispatch_pd, imm: dispatch_imm, rob_tag: dispatch_rob_tag};
      it.r1 = dispatch_ps1_ready || dispatch_ps1 == 7'd0 || hit(dispatch_ps1);
      it.r2 = dispatch_opcode == OPC_LOAD || dispatch_ps2_ready || dispatch_ps2 == 7'd0 ||
              hit(dispatch_ps2);
      mq.push_back(it);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("issued", issued, exp_issued);
    check("issue_data", issue_data, exp_data);
    check("rs_count", rs_count, mq.size());
    check("rs_full", rs_full, mq.size() == DEPTH);
`ifdef RS_MEM_PERF_EN
    check("stall_cycles", stall_cycles, exp_stall);
`endif
    if (issued) dut_tags.push_back(int'(issue_data.rob_tag));
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
    cdb_pd         = '0;
    mispredict     = 1'b0;
  endtask

  task automatic disp(input bit ld, input logic [6:0] p1, input logic [6:0] p2,
                      input bit r1, input bit r2, input logic [4:0] tag);
    dispatch_valid     = 1'b1;
    dispatch_opcode    = ld ? OPC_LOAD : OPC_STORE;
    dispatch_funct3    = 3'($urandom_range(0, 7));
    dispatch_ps1       = p1;
    dispatch_ps2       = p2;
    dispatch_ps1_ready = r1;
    dispatch_ps2_ready = r2;
    dispatch_pd        = ld ? 7'($urandom_range(1, 127)) : 7'd0;
    dispatch_imm       = $urandom;
    dispatch_rob_tag   = tag;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    #2;
    check("rst_issued", issued, 0);
    check("rst_data", issue_data, 0);
    check("rst_count", rs_count, 0);
    check("rst_full", rs_full, 0);
`ifdef RS_MEM_PERF_EN
    check("rst_stall", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    dut_tags.delete();
    exp_issued = 1'b0;
    exp_data   = '0;
    exp_stall  = '0;
  endtask

  initial begin
    logic [4:0] next_tag;
    reset = 1'b1;
    idle();
    disp(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 5'd0);
    dispatch_valid = 1'b0;
    rob_head       = '0;
    mispredict_tag = '0;
    fu_mem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Load ready at dispatch issues two edges later.
    fu_mem_ready = 1'b1;
    disp(1'b1, 7'd5, 7'd0, 1'b1, 1'b0, 5'd3);
    cycle();
    idle();
    check("t1_not_yet", issued, 0);
    cycle();
    check("t1_issued", issued, 1);
    check("t1_tag", issue_data.rob_tag, 3);
    check("t1_count", rs_count, 0);

    // Store woken by CDB ports 0 then 2.
    disp(1'b0, 7'd12, 7'd13, 1'b0, 1'b0, 5'd4);
    cycle();
    idle();
    cycle();
    cycle();
    cdb_valid = 3'b001; cdb_pd = {7'd0, 7'd0, 7'd12};
    cycle();
    idle();
    cycle();
    cdb_valid = 3'b100; cdb_pd = {7'd13, 7'd0, 7'd0};
    cycle();
    idle();
    check("t2_not_before", issued, 0);
    cycle();
    check("t2_issued", issued, 1);
    check("t2_tag", issue_data.rob_tag, 4);

    // Fill, overflow, then free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b0, 7'(20 + i), 7'(40 + i), 1'b0, 1'b0, 5'(8 + i));
      cycle();
    end
    check("t3_full", rs_full, 1);
    check("t3_count", rs_count, 8);
    disp(1'b0, 7'd30, 7'd50, 1'b0, 1'b0, 5'd16);
    cycle();
    idle();
    check("t3_dropped", rs_count, 8);
    cdb_valid = 3'b011; cdb_pd = {7'd0, 7'd40, 7'd20};
    cycle();
    idle();
    cycle();
    check("t3_issue_tag", issue_data.rob_tag, 8);
    check("t3_not_full", rs_full, 0);
    do_reset();

    // Wrap-around age ordering.
    rob_head     = 5'd30;
    fu_mem_ready = 1'b0;
    disp(1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 5'd3);  cycle();
    disp(1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 5'd1);  cycle();
    disp(1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 5'd31); cycle();
    idle();
    fu_mem_ready = 1'b1;
    repeat (4) cycle();
    check("t4_n", dut_tags.size(), 3);
    check("t4_first", dut_tags[0], 31);
    check("t4_second", dut_tags[1], 1);
    check("t4_third", dut_tags[2], 3);
    do_reset();

    // Mispredict flushes younger entries only.
    rob_head     = 5'd0;
    fu_mem_ready = 1'b0;
    disp(1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 5'd2); cycle();
    disp(1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 5'd5); cycle();
    disp(1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 5'd7); cycle();
    idle();
    mispredict = 1'b1; mispredict_tag = 5'd4;
    cycle();
    idle();
    check("t5_count", rs_count, 1);
    fu_mem_ready = 1'b1;
    repeat (3) cycle();
    check("t5_n", dut_tags.size(), 1);
    check("t5_tag", dut_tags[0], 2);
    do_reset();

    // Blocked ready entry, then reset mid-operation.
    fu_mem_ready = 1'b0;
    disp(1'b1, 7'd9, 7'd0, 1'b1, 1'b0, 5'd6);
    cycle();
    idle();
    repeat (4) cycle();
    check("t6_no_issue", dut_tags.size(), 0);
`ifdef RS_MEM_PERF_EN
    check("t6_stall", stall_cycles, 4);
`endif
    do_reset();

    // Randomized traffic against the reference model.
    rob_head = 5'($urandom_range(0, 31));
    next_tag = rob_head;
    for (int c = 0; c < 400; c++) begin
      idle();
      if (c % 25 == 24) rob_head = 5'($urandom_range(0, 31));
      fu_mem_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid[k]     = ($urandom_range(0, 9) < 4);
        cdb_pd[7*k +: 7] = 7'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) < 6 && mq.size() < DEPTH) begin
        while (tag_live(next_tag)) next_tag = next_tag + 5'd1;
        disp($urandom_range(0, 1) == 1, 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, next_tag);
        next_tag = next_tag + 5'd1;
      end
      if ($urandom_range(0, 99) < 5) begin
        mispredict     = 1'b1;
        mispredict_tag = 5'($urandom_range(0, 31));
      end
      cycle();
    end
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
